// File: rtl/arm_pipe_pkg.sv
// Purpose: payload types shared by the ARM pipeline register chain and its users.
// Latency: n/a (types, widths and small helpers only).
// Backpressure: n/a.
//
// Contents:
//   id_exe_t / ID_EXE_W    - ID/EXE boundary payload (control bits, operands, immediates)
//   exe_mem_t / EXE_MEM_W  - EXE/MEM boundary payload (control bits, ALU result, store data)
//   id_exe_nop()           - all-zero ID/EXE payload; decodes as a NOP
package arm_pipe_pkg;

    typedef struct packed {
        logic        status_en;  // update CPSR flags
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        branch;
        logic        i_flag;     // I bit: operand 2 is an immediate
        logic [3:0]  alu_cmd;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;     // NZCV captured at decode
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [23:0] imm24;
        logic [11:0] shift12;
    } id_exe_t;

    localparam int ID_EXE_W = $bits(id_exe_t);

    typedef struct packed {
        logic        wb_en;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] st_val;
    } exe_mem_t;

    localparam int EXE_MEM_W = $bits(exe_mem_t);

    // Zeroed payload: no writeback, no memory access, no flag update.
    function automatic id_exe_t id_exe_nop();
        id_exe_t p;
        p = '0;
        return p;
    endfunction

endpackage

// File: rtl/arm_pipe_stage_reg.sv
// Purpose: one pipeline boundary register, a valid bit plus DATA_W payload.
// Latency: 1 cycle from load to valid output.
// Backpressure: none locally; the chain decides load/clear, otherwise the stage holds.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   load, load_data - capture load_data and mark valid (wins over clear)
//   clear           - mark invalid; payload is left untouched
//   valid, data     - registered state
module arm_pipe_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Payload only changes on load, so a held or killed stage keeps its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arm_pipe_chain.sv
// Purpose: parametrised chain of STAGES pipeline registers with valid bits, bubble collapse, freeze and flush.
// Latency: STAGES cycles input to output when unstalled; 1 item/cycle throughput.
// Backpressure: valid/ready; empty stages accept even when downstream stalls, in_ready is combinational.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   in_valid/in_data/in_ready - upstream handshake into stage 0
//   freeze                    - hold stages 0..FRZ_STAGE, stage FRZ_STAGE+1 receives a bubble
//   flush, flush_mask         - kill the current content of the masked stages this cycle
//   out_valid/out_data        - registered stage STAGES-1 contents, out_ready from downstream
//   stage_valid, occupancy    - per-stage valid bits and their popcount
// Optional: define PIPE_PERF_CNT_EN to add stall_cnt and bubble_cnt counters.
module arm_pipe_chain
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int STAGES    = 4,
    parameter int FRZ_STAGE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        freeze,
    input  logic                        flush,
    input  logic [STAGES-1:0]           flush_mask,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [STAGES-1:0]           stage_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 bubble_cnt
`endif
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] v;
    logic [DATA_W-1:0] d   [STAGES];
    logic [DATA_W-1:0] src [STAGES];

    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] ev;
    logic [STAGES-1:0] mv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] clear;
    logic              acc0;
    logic              in_fire;
    logic [OCC_W-1:0]  occ_sum;

    // Move/accept resolve from the oldest stage downwards: a stage can move
    // only if the one above accepts, and an empty stage always accepts.
    always_comb begin
        logic acc_up;
        acc_up = 1'b0;
        kill   = '0;
        ev     = '0;
        mv     = '0;
        for (int i = STAGES-1; i >= 0; i--) begin
            kill[i] = flush & flush_mask[i];
            ev[i]   = v[i] & ~kill[i];
            if (i == STAGES-1) begin
                mv[i] = ev[i] & out_ready;
            end else begin
                mv[i] = ev[i] & acc_up & ~(freeze & (i <= FRZ_STAGE));
            end
            acc_up = ~ev[i] | mv[i];
        end
        acc0 = acc_up;
    end

    assign in_ready = acc0 & ~freeze;
    assign in_fire  = in_valid & in_ready;

    // A load beats a clear; a killed stage that neither loads nor moves just
    // drops its valid bit. A killed stage 0 also discards the incoming item.
    always_comb begin
        load  = '0;
        clear = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (i == 0) begin
                load[i] = in_fire & ~kill[0];
            end else begin
                load[i] = mv[i-1];
            end
            clear[i] = ~load[i] & (mv[i] | kill[i]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_src_in
                assign src[g] = in_data;
            end else begin : g_src_prev
                assign src[g] = d[g-1];
            end

            arm_pipe_stage_reg #(
                .DATA_W (DATA_W)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .load      (load[g]),
                .clear     (clear[g]),
                .load_data (src[g]),
                .valid     (v[g]),
                .data      (d[g])
            );
        end
    endgenerate

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(v[i]);
        end
    end

    assign stage_valid = v;
    assign occupancy   = occ_sum;
    assign out_valid   = v[STAGES-1];
    assign out_data    = d[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
    // Free-running wrap-around counters of input stalls and output bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid & ~in_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (~out_valid & (occ_sum != '0)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arm_pipe_chain.sv
// Purpose: self-checking bench for arm_pipe_chain (STAGES=4, DATA_W=32, FRZ_STAGE=1).
// Latency: n/a.
// Backpressure: n/a.
module tb_arm_pipe_chain;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        freeze;
    logic        flush;
    logic [3:0]  flush_mask;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  stage_valid;
    logic [2:0]  occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    arm_pipe_chain #(
        .DATA_W    (32),
        .STAGES    (4),
        .FRZ_STAGE (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .freeze      (freeze),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs held for the cycle, in_ready expected
    // before the edge, registered outputs expected after it.
    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        frz;
        logic        fl;
        logic [3:0]  fm;
        logic        x_ir;
        logic        x_ov;
        logic [31:0] x_od;
        logic [3:0]  x_sv;
        logic [2:0]  x_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic frz, input logic fl, input logic [3:0] fm,
                       input logic x_ir, input logic x_ov, input logic [31:0] x_od,
                       input logic [3:0] x_sv, input logic [2:0] x_occ);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.frz = frz; r.fl = fl; r.fm = fm;
        r.x_ir = x_ir; r.x_ov = x_ov; r.x_od = x_od; r.x_sv = x_sv; r.x_occ = x_occ;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input int step,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic frz, input logic fl, input logic [3:0] fm);
        in_valid = iv; in_data = id; out_ready = ordy;
        freeze = frz; flush = fl; flush_mask = fm;
    endtask

    initial begin
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;

        //   iv id     ordy frz fl  fm       ir  ov  od     sv       occ
        // streaming fill; flush=0 with a full mask must be ignored (step 5)
        add(1, 32'd1,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0001, 3'd1);
        add(1, 32'd2,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0011, 3'd2);
        add(1, 32'd3,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0111, 3'd3);
        add(1, 32'd4,  1, 0, 0, 4'b0000, 1, 1, 32'd1,  4'b1111, 3'd4);
        add(1, 32'd5,  1, 0, 0, 4'b1111, 1, 1, 32'd2,  4'b1111, 3'd4);
        add(1, 32'd6,  1, 0, 0, 4'b0000, 1, 1, 32'd3,  4'b1111, 3'd4);
        // freeze for two cycles: stages 0-1 hold, stage 2 becomes a bubble
        add(1, 32'd7,  1, 1, 0, 4'b0000, 0, 1, 32'd4,  4'b1011, 3'd3);
        add(1, 32'd7,  1, 1, 0, 4'b0000, 0, 0, 32'd0,  4'b0011, 3'd2);
        add(1, 32'd7,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0111, 3'd3);
        add(1, 32'd8,  1, 0, 0, 4'b0000, 1, 1, 32'd5,  4'b1111, 3'd4);
        add(1, 32'd9,  1, 0, 0, 4'b0000, 1, 1, 32'd6,  4'b1111, 3'd4);
        // drain
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'd7,  4'b1110, 3'd3);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'd8,  4'b1100, 3'd2);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'd9,  4'b1000, 3'd1);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0000, 3'd0);
        // backpressure collapse: six cycles of out_ready=0
        add(1, 32'hA,  0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0001, 3'd1);
        add(1, 32'hB,  0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0011, 3'd2);
        add(1, 32'hC,  0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0111, 3'd3);
        add(1, 32'hD,  0, 0, 0, 4'b0000, 1, 1, 32'hA,  4'b1111, 3'd4);
        add(1, 32'hE,  0, 0, 0, 4'b0000, 0, 1, 32'hA,  4'b1111, 3'd4);
        add(1, 32'hE,  0, 0, 0, 4'b0000, 0, 1, 32'hA,  4'b1111, 3'd4);
        add(1, 32'hE,  1, 0, 0, 4'b0000, 1, 1, 32'hB,  4'b1111, 3'd4);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'hC,  4'b1110, 3'd3);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'hD,  4'b1100, 3'd2);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'hE,  4'b1000, 3'd1);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0000, 3'd0);
        // fill 13 (oldest) .. 10, then flush the two youngest with 14 offered
        add(1, 32'd13, 0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0001, 3'd1);
        add(1, 32'd12, 0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0011, 3'd2);
        add(1, 32'd11, 0, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0111, 3'd3);
        add(1, 32'd10, 0, 0, 0, 4'b0000, 1, 1, 32'd13, 4'b1111, 3'd4);
        add(1, 32'd14, 0, 0, 1, 4'b0011, 1, 1, 32'd13, 4'b1100, 3'd2);
        // refill to 20,21,22 in stages 2..0, then freeze+flush of stage 0
        add(1, 32'd20, 1, 0, 0, 4'b0000, 1, 1, 32'd12, 4'b1001, 3'd2);
        add(1, 32'd21, 1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0011, 3'd2);
        add(1, 32'd22, 1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0111, 3'd3);
        add(1, 32'd23, 0, 1, 1, 4'b0001, 0, 1, 32'd20, 4'b1010, 3'd2);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0100, 3'd1);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 1, 32'd21, 4'b1000, 3'd1);
        add(0, 32'd0,  1, 0, 0, 4'b0000, 1, 0, 32'd0,  4'b0000, 3'd0);

        // reset state, sampled while reset is still asserted
        #2;
        check("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
        check("rst_out_data", 0, out_data, 32'd0);
        check("rst_stage_valid", 0, {28'd0, stage_valid}, 32'd0);
        check("rst_occupancy", 0, {29'd0, occupancy}, 32'd0);
        #18;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].iv, vecs[k].id, vecs[k].ordy, vecs[k].frz, vecs[k].fl, vecs[k].fm);
            #1;
            check("in_ready", k + 1, {31'd0, in_ready}, {31'd0, vecs[k].x_ir});
            @(posedge clk);
            #1;
            check("out_valid", k + 1, {31'd0, out_valid}, {31'd0, vecs[k].x_ov});
            if (vecs[k].x_ov) begin
                check("out_data", k + 1, out_data, vecs[k].x_od);
            end
            check("stage_valid", k + 1, {28'd0, stage_valid}, {28'd0, vecs[k].x_sv});
            check("occupancy", k + 1, {29'd0, occupancy}, {29'd0, vecs[k].x_occ});
        end

`ifdef PIPE_PERF_CNT_EN
        check("stall_cnt", 100, stall_cnt, 32'd5);
        check("bubble_cnt", 100, bubble_cnt, 32'd14);
`endif

        // asynchronous reset in the middle of a full stream
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'd50 + 32'(k), 1'b1, 1'b0, 1'b0, 4'b0000);
            @(posedge clk);
            #1;
        end
        check("pre_arst_occupancy", 200, {29'd0, occupancy}, 32'd4);
        #1;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 201, {31'd0, out_valid}, 32'd0);
        check("arst_out_data", 201, out_data, 32'd0);
        check("arst_stage_valid", 201, {28'd0, stage_valid}, 32'd0);
        check("arst_occupancy", 201, {29'd0, occupancy}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check("arst_stall_cnt", 201, stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        check("arst_held_occupancy", 202, {29'd0, occupancy}, 32'd0);
        rst = 1'b1;

        // restart: 100 is the first item out, four edges after acceptance
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'd100 + 32'(k), 1'b1, 1'b0, 1'b0, 4'b0000);
            @(posedge clk);
            #1;
            if (k < 3) begin
                check("restart_out_valid", 210 + k, {31'd0, out_valid}, 32'd0);
                check("restart_occupancy", 210 + k, {29'd0, occupancy}, 32'(k + 1));
            end else begin
                check("restart_out_valid", 210 + k, {31'd0, out_valid}, 32'd1);
                check("restart_out_data", 210 + k, out_data, 32'd100 + 32'(k - 3));
            end
        end

        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_pipe_chain.md
Name: arm_pipe_chain

Overview:
- Parametrised chain of pipeline registers that replaces the hand-written, fixed-field IF/ID, ID/EXE, EXE/MEM and MEM/WB register modules.
- Carries a packed DATA_W-bit payload per stage with a valid bit.
- Provides bubble-collapsing flow control, hazard freeze with bubble injection, and per-stage flush for taken branches.
- Sits between stage logic in the ARM datapath; one instance per group of consecutive pipeline boundaries.

Parameters:
DATA_W, 32, payload width per stage (packed control and data fields)
STAGES, 4, number of register stages (>=2); stage 0 is youngest, next to input
FRZ_STAGE, 0, highest stage index held by freeze (0..STAGES-2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
in_valid  in  1  upstream item present
in_data  in  DATA_W  upstream payload
in_ready  out  1  stage 0 can accept this cycle
freeze  in  1  hazard stall: hold stages 0..FRZ_STAGE
flush  in  1  branch flush strobe
flush_mask  in  STAGES  stages whose current content is killed when flush=1
out_valid  out  1  stage STAGES-1 holds valid item
out_data  out  DATA_W  stage STAGES-1 payload
out_ready  in  1  downstream accepts
stage_valid  out  STAGES  valid bit of every stage
occupancy  out  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all data 0, occupancy 0, out_valid 0. Release is synchronous to clk; first load is possible on the first edge after release.
- Effective valid: ev[i] = v[i] & ~(flush & flush_mask[i]).
- Move out of stage i:
  - i = STAGES-1: mv[i] = ev[i] & out_ready.
  - otherwise: mv[i] = ev[i] & acc[i+1] & ~(freeze & i<=FRZ_STAGE).
- Accept into stage i: acc[i] = ~ev[i] | mv[i]. Bubbles collapse because an empty stage accepts even if downstream is stalled.
- Input handshake: in_ready = acc[0] & ~freeze, combinational.
- Next state for stage i >= 1:
  - if mv[i-1], load d[i-1] and set v=1;
  - else if mv[i], set v=0;
  - else keep, with v forced 0 if killed.
- Next state for stage 0: same rule with the input handshake as source. The input is dropped (v stays 0) if flush & flush_mask[0].
- Freeze: stages 0..FRZ_STAGE hold their contents. Stage FRZ_STAGE+1 receives nothing; if it drains it becomes a bubble (ARM hazard semantics: IF/ID held, ID/EXE gets a NOP).
- Flush: a killed item never propagates and its stage is invalid after the edge unless refilled from upstream.
  - Flush overrides freeze for the masked stages.
  - flush=0 ignores flush_mask.
- out_valid and out_data are registered (v[STAGES-1], d[STAGES-1]). Latency from input to output is STAGES cycles when unstalled. Throughput is 1 item per cycle.
- Data of invalid stages is don't-care but must not change while the stage is held.
- occupancy is the popcount of v, registered-derived, combinational from the flops.
- Asynchronous reset mid-transfer: all in-flight items are lost; no partial state survives.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cnt [31:0] and bubble_cnt [31:0].
  - stall_cnt increments each cycle with in_valid & ~in_ready.
  - bubble_cnt increments each cycle with out_valid=0 & occupancy!=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package arm_pipe_pkg holds:
  - the typedefs for the packed ID/EXE and EXE/MEM payload structs (status_en, mem_read, mem_write, wb_en, branch, I, alu_cmd[3:0], dest[3:0], src1/src2[3:0], status[3:0], pc[31:0], reg1/reg2[31:0], imm24, shift12);
  - localparams for their widths.
- Sub-module arm_pipe_stage_reg: one valid+data register with load/clear/hold controls, instantiated STAGES times by generate.

Test Plan:
All scenarios use STAGES=4, DATA_W=32, FRZ_STAGE=1.
- Streaming: in_valid=1 with data 1,2,3,... and out_ready=1 -> out_data=1 appears 4 cycles after the first accept, then one item per cycle; occupancy settles at 4.
- Backpressure collapse: load 0xA, hold out_ready=0 for 6 cycles while feeding 0xB, 0xC, 0xD, 0xE -> stage_valid=4'b1111, in_ready=0; on the out_ready rise, items emerge in order A, B, C, D, E.
- Freeze bubble: steady stream, then freeze=1 for 2 cycles -> in_ready=0; stages 0–1 hold; stage 2 shows valid=0 the next cycle; the output shows a 2-item gap; nothing is lost or duplicated.
- Flush: pipe full of 10, 11, 12, 13 (13 oldest), then flush=1 with flush_mask=4'b0011 and in_valid=1 with 14 -> after the edge only 12 and 13 remain and 14 is dropped; occupancy goes 4 -> 2 (with out_ready=0).
- Freeze+flush together: freeze=1, flush=1, flush_mask=4'b0001 -> stage 0 invalid, stage 1 held, stage 2 bubble.
- Async reset: pulse rst=0 mid-clock during streaming -> all outputs go 0 immediately without a clk edge; the stream restarts cleanly after release.
